// File: rtl/axi_rd_burst_master_pkg.sv
// axi_rd_burst_master_pkg: AXI constants, FSM state type and log2 helper
// shared by the read burst master and its burst-length calculator.
package axi_rd_burst_master_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    function automatic int unsigned c_log_2(input int unsigned v);
        return $clog2(v);
    endfunction

endpackage

// File: rtl/axi_rd_burst_master_if.sv
// axi_rd_burst_master_if: request, AXI AR/R and read-buffer signals of one
// read burst master; master = the burst master itself, slave = its environment.
interface axi_rd_burst_master_if #(
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned TX_SIZE_WIDTH  = 10
);
    logic                      rx_req;
    logic [31:0]               rx_addr;
    logic [TX_SIZE_WIDTH-1:0]  rx_req_size;
    logic                      rx_req_ready;
    logic                      rx_done;
    logic                      rx_err;
    logic [31:0]               araddr;
    logic [7:0]                arlen;
    logic [2:0]                arsize;
    logic [1:0]                arburst;
    logic                      arvalid;
    logic                      arready;
    logic [AXI_DATA_WIDTH-1:0] rdata;
    logic [1:0]                rresp;
    logic                      rlast;
    logic                      rvalid;
    logic                      rready;
    logic [AXI_DATA_WIDTH-1:0] rd_buf_data;
    logic                      rd_buf_push;
    logic                      rd_buf_full;

    modport master (
        input  rx_req, rx_addr, rx_req_size, arready, rdata, rresp, rlast, rvalid, rd_buf_full,
        output rx_req_ready, rx_done, rx_err, araddr, arlen, arsize, arburst, arvalid, rready,
               rd_buf_data, rd_buf_push
    );

    modport slave (
        output rx_req, rx_addr, rx_req_size, arready, rdata, rresp, rlast, rvalid, rd_buf_full,
        input  rx_req_ready, rx_done, rx_err, araddr, arlen, arsize, arburst, arvalid, rready,
               rd_buf_data, rd_buf_push
    );

endinterface

// File: rtl/axi_burst_len_calc.sv
// axi_burst_len_calc: AXI4 INCR arlen for the next burst, limited by the
// remaining beats, the maximum burst length and the next 4 KB boundary.
module axi_burst_len_calc
    import axi_rd_burst_master_pkg::*;
#(
    parameter int unsigned BYTES         = 8,
    parameter int unsigned TX_SIZE_WIDTH = 10,
    parameter int unsigned MAX_BURST_LEN = 16
) (
    input  logic [31:0]              addr_i,
    input  logic [TX_SIZE_WIDTH-1:0] remaining_i,
    output logic [7:0]               arlen_o
);

    localparam int unsigned SH = c_log_2(BYTES);

    logic [31:0] page_beats;
    logic [31:0] rem_beats;
    logic [31:0] cap_beats;
    logic [31:0] beats;

    always_comb begin
        page_beats = (32'd4096 - {20'd0, addr_i[11:0]}) >> SH;
        rem_beats  = 32'(remaining_i);
        cap_beats  = (rem_beats < 32'(MAX_BURST_LEN)) ? rem_beats : 32'(MAX_BURST_LEN);
        beats      = (page_beats < cap_beats) ? page_beats : cap_beats;
        arlen_o    = 8'(beats - 32'd1);
    end

endmodule

// File: rtl/axi_rd_burst_master.sv
// axi_rd_burst_master: splits one read request into 4 KB-safe AXI4 INCR bursts,
// caps outstanding bursts and forwards every R beat straight into the read buffer.
module axi_rd_burst_master
    import axi_rd_burst_master_pkg::*;
#(
    parameter int unsigned AXI_DATA_WIDTH  = 64,
    parameter int unsigned TX_SIZE_WIDTH   = 10,
    parameter int unsigned MAX_BURST_LEN   = 16,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    axi_rd_burst_master_if.master bus_io
);

    localparam int unsigned BYTES = AXI_DATA_WIDTH / 8;
    localparam int unsigned SH    = c_log_2(BYTES);
    localparam int unsigned OW    = c_log_2(MAX_OUTSTANDING + 1);
    localparam int unsigned TW    = TX_SIZE_WIDTH;

    state_e          state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     araddr_q, araddr_d;
    logic [7:0]      arlen_q, arlen_d;
    logic            arvalid_q, arvalid_d;
    logic [TW-1:0]   remaining_q, remaining_d;
    logic [TW-1:0]   total_q, total_d;
    logic [TW-1:0]   rcvd_q, rcvd_d;
    logic [OW-1:0]   outst_q, outst_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic [31:0]     calc_addr;
    logic [TW-1:0]   calc_rem;
    logic [7:0]      calc_len;
    logic            rready;
    logic            push;
    logic            ar_hs;

    // In IDLE the first burst is sized from the incoming request directly
    assign calc_addr = (state_q == IDLE) ? bus_io.rx_addr : addr_q;
    assign calc_rem  = (state_q == IDLE) ? bus_io.rx_req_size : remaining_q;

    axi_burst_len_calc #(
        .BYTES         (BYTES),
        .TX_SIZE_WIDTH (TX_SIZE_WIDTH),
        .MAX_BURST_LEN (MAX_BURST_LEN)
    ) u_len_calc (
        .addr_i      (calc_addr),
        .remaining_i (calc_rem),
        .arlen_o     (calc_len)
    );

    assign rready = (state_q != IDLE) && !bus_io.rd_buf_full;
    assign push   = bus_io.rvalid && rready;
    assign ar_hs  = arvalid_q && bus_io.arready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        araddr_d    = araddr_q;
        arlen_d     = arlen_q;
        arvalid_d   = arvalid_q;
        remaining_d = remaining_q;
        total_d     = total_q;
        rcvd_d      = rcvd_q;
        outst_d     = outst_q;
        done_d      = 1'b0;
        err_d       = err_q;
        if (state_q == IDLE) begin
            if (bus_io.rx_req) begin
                addr_d      = bus_io.rx_addr;
                remaining_d = bus_io.rx_req_size;
                total_d     = bus_io.rx_req_size;
                rcvd_d      = '0;
                err_d       = 1'b0;
                done_d      = (bus_io.rx_req_size == '0);
                state_d     = (bus_io.rx_req_size == '0) ? IDLE : ISSUE;
                if (bus_io.rx_req_size != '0) begin
                    arvalid_d = 1'b1;
                    araddr_d  = bus_io.rx_addr;
                    arlen_d   = calc_len;
                end
            end
        end else begin
            rcvd_d  = rcvd_q + TW'(push);
            err_d   = err_q || (push && bus_io.rresp != AXI_RESP_OKAY);
            outst_d = outst_q + OW'(ar_hs) - OW'(push && bus_io.rlast);
            if (ar_hs) begin
                arvalid_d   = 1'b0;
                addr_d      = addr_q + ((32'(arlen_q) + 32'd1) << SH);
                remaining_d = remaining_q - (TW'(arlen_q) + TW'(1));
                state_d     = (remaining_d == '0) ? DRAIN : ISSUE;
            end else if (state_q == ISSUE && !arvalid_q && outst_q < OW'(MAX_OUTSTANDING)) begin
                arvalid_d = 1'b1;
                araddr_d  = addr_q;
                arlen_d   = calc_len;
            end
            // Completion is flagged on the edge that takes the final beat
            if (state_q == DRAIN && push && rcvd_d == total_q) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            araddr_q    <= '0;
            arlen_q     <= '0;
            arvalid_q   <= 1'b0;
            remaining_q <= '0;
            total_q     <= '0;
            rcvd_q      <= '0;
            outst_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            araddr_q    <= araddr_d;
            arlen_q     <= arlen_d;
            arvalid_q   <= arvalid_d;
            remaining_q <= remaining_d;
            total_q     <= total_d;
            rcvd_q      <= rcvd_d;
            outst_q     <= outst_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus_io.rx_req_ready = resetn && (state_q == IDLE);
    assign bus_io.rx_done      = done_q;
    assign bus_io.rx_err       = err_q;
    assign bus_io.araddr       = araddr_q;
    assign bus_io.arlen        = arlen_q;
    assign bus_io.arsize       = 3'(SH);
    assign bus_io.arburst      = AXI_BURST_INCR;
    assign bus_io.arvalid      = arvalid_q;
    assign bus_io.rready       = rready;
    assign bus_io.rd_buf_push  = push;
    assign bus_io.rd_buf_data  = bus_io.rdata;

endmodule

// File: tb/tb_axi_rd_burst_master.sv
// tb_axi_rd_burst_master: AXI slave model with random handshakes, checked
// against burst lists and beat sequences computed from the splitting rules.
module tb_axi_rd_burst_master;

    localparam int BYTES = 8;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    axi_rd_burst_master_if bus ();

    axi_rd_burst_master dut (
        .clk    (clk),
        .resetn (resetn),
        .bus_io (bus)
    );

    int n_checks = 0;
    int n_fail = 0;

    bit ar_rand = 0, r_rand = 0, r_on = 1;
    int err_beat = -1;
    int bq[$];
    int cur_beat = 0;
    bit r_busy = 0;
    int seq = 0;
    logic [31:0] log_addr[$];
    logic [7:0]  log_len[$];
    int          log_cyc[$];
    logic [63:0] push_log[$];
    logic [31:0] exp_addr[$];
    logic [7:0]  exp_len[$];
    int cyc = 0, done_cnt = 0, done_cyc = 0, last_push_cyc = 0, first_rlast_cyc = -1;
    int outs = 0, max_outs = 0, push_while_full = 0, rready_while_full = 0, full_cycles = 0;
    bit err_at_done = 0, ready_at_done = 0;
    int acc_cyc = 0;
    logic arv_acc, err_acc;

    // AXI read slave: returns beat sequence numbers as data, one beat at a time
    initial begin
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00; bus.rlast = 1'b0;
        forever begin
            @(negedge clk);
            bus.arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!r_busy && bq.size() > 0 && r_on && (!r_rand || $urandom_range(0, 2) != 0)) begin
                r_busy = 1;
                bus.rvalid = 1'b1;
                bus.rdata = 64'(seq);
                bus.rlast = (cur_beat == bq[0] - 1);
                bus.rresp = (seq == err_beat) ? 2'b10 : 2'b00;
            end else if (!r_busy) bus.rvalid = 1'b0;
            #1;
            cyc++;
            if (bus.arvalid && bus.arready) begin
                log_addr.push_back(bus.araddr);
                log_len.push_back(bus.arlen);
                log_cyc.push_back(cyc);
                bq.push_back(int'(bus.arlen) + 1);
                outs++;
            end
            if (bus.rvalid && bus.rready) begin
                seq++;
                r_busy = 0;
                if (bus.rlast) begin
                    void'(bq.pop_front());
                    cur_beat = 0;
                    outs--;
                    if (first_rlast_cyc < 0) first_rlast_cyc = cyc;
                end else cur_beat++;
            end
            if (outs > max_outs) max_outs = outs;
            if (bus.rd_buf_push) begin push_log.push_back(bus.rd_buf_data); last_push_cyc = cyc; end
            if (bus.rd_buf_full) full_cycles++;
            if (bus.rd_buf_full && bus.rd_buf_push) push_while_full++;
            if (bus.rd_buf_full && bus.rready) rready_while_full++;
            if (bus.rx_done) begin
                done_cnt++;
                done_cyc = cyc;
                err_at_done = bus.rx_err;
                ready_at_done = bus.rx_req_ready;
            end
        end
    end

    function automatic void build_model(input logic [31:0] a, input int size);
        int rem, page, n;
        exp_addr.delete();
        exp_len.delete();
        rem = size;
        while (rem > 0) begin
            page = (4096 - int'(a[11:0])) / BYTES;
            n = (rem < 16) ? rem : 16;
            n = (page < n) ? page : n;
            exp_addr.push_back(a);
            exp_len.push_back(8'(n - 1));
            a = a + 32'(n * BYTES);
            rem -= n;
        end
    endfunction

    task automatic slave_clear();
        bq.delete();
        r_busy = 0; cur_beat = 0; seq = 0; outs = 0; bus.rvalid = 1'b0;
    endtask

    task automatic start_req(input logic [31:0] a, input int size);
        build_model(a, size);
        log_addr.delete(); log_len.delete(); log_cyc.delete(); push_log.delete();
        done_cnt = 0; seq = 0; first_rlast_cyc = -1; max_outs = 0;
        push_while_full = 0; rready_while_full = 0; full_cycles = 0;
        for (int i = 0; i < 100 && !bus.rx_req_ready; i++) @(negedge clk);
        @(posedge clk); #1;
        bus.rx_req = 1'b1; bus.rx_addr = a; bus.rx_req_size = 10'(size);
        @(posedge clk); #1;
        bus.rx_req = 1'b0; bus.rx_addr = $urandom; bus.rx_req_size = 10'($urandom);
        @(negedge clk); #2;
        acc_cyc = cyc; arv_acc = bus.arvalid; err_acc = bus.rx_err;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 4000 && done_cnt == 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        #2;
    endtask

    task automatic test_reset();
        bus.rx_req = 1'b0; bus.rx_addr = '0; bus.rx_req_size = '0; bus.rd_buf_full = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        n_checks++; if (bus.arvalid !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid: got %0h want 0", bus.arvalid); end
        n_checks++; if (bus.araddr !== 32'h0) begin n_fail++; $display("FAIL reset_araddr: got %0h want 0", bus.araddr); end
        n_checks++; if (bus.arlen !== 8'h0) begin n_fail++; $display("FAIL reset_arlen: got %0h want 0", bus.arlen); end
        n_checks++; if (bus.rready !== 1'b0) begin n_fail++; $display("FAIL reset_rready: got %0h want 0", bus.rready); end
        n_checks++; if (bus.rd_buf_push !== 1'b0) begin n_fail++; $display("FAIL reset_push: got %0h want 0", bus.rd_buf_push); end
        n_checks++; if (bus.rx_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0h want 0", bus.rx_done); end
        n_checks++; if (bus.rx_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0h want 0", bus.rx_err); end
        n_checks++; if (bus.rx_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_low: got %0h want 0", bus.rx_req_ready); end
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk); #2;
        n_checks++; if (bus.rx_req_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %0h want 1", bus.rx_req_ready); end
        n_checks++; if (bus.arsize !== 3'd3) begin n_fail++; $display("FAIL arsize: got %0h want 3", bus.arsize); end
        n_checks++; if (bus.arburst !== 2'b01) begin n_fail++; $display("FAIL arburst: got %0h want 1", bus.arburst); end
    endtask

    task automatic test_long();
        ar_rand = 0; r_rand = 0; r_on = 1;
        start_req(32'h1000, 128);
        wait_done();
        n_checks++; if (arv_acc !== 1'b1) begin n_fail++; $display("FAIL long_first_arvalid: got %0h want 1", arv_acc); end
        n_checks++; if (log_addr.size() != 8) begin n_fail++; $display("FAIL long_ar_count: got %0d want 8", log_addr.size()); end
        for (int i = 0; i < 8 && i < log_addr.size(); i++) begin
            n_checks++; if (log_addr[i] !== 32'h1000 + 32'(i) * 32'h80 || log_len[i] !== 8'd15) begin
                n_fail++; $display("FAIL long_ar%0d: got %0h/%0d want %0h/15", i, log_addr[i], log_len[i], 32'h1000 + 32'(i) * 32'h80);
            end
        end
        n_checks++; if (push_log.size() != 128) begin n_fail++; $display("FAIL long_pushes: got %0d want 128", push_log.size()); end
        for (int i = 0; i < push_log.size() && i < 128; i++) begin
            n_checks++; if (push_log[i] !== 64'(i)) begin n_fail++; $display("FAIL long_data%0d: got %0h want %0h", i, push_log[i], i); end
        end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL long_done_count: got %0d want 1", done_cnt); end
        n_checks++; if (done_cyc != last_push_cyc + 1) begin n_fail++; $display("FAIL long_done_timing: got %0d want %0d", done_cyc, last_push_cyc + 1); end
        n_checks++; if (ready_at_done !== 1'b1) begin n_fail++; $display("FAIL long_ready_at_done: got %0h want 1", ready_at_done); end
        n_checks++; if (err_at_done !== 1'b0) begin n_fail++; $display("FAIL long_err: got %0h want 0", err_at_done); end
    endtask

    task automatic test_4k_cross();
        ar_rand = 0; r_rand = 1; r_on = 1;
        start_req(32'h1FC0, 20);
        wait_done();
        n_checks++; if (log_addr.size() != 2) begin n_fail++; $display("FAIL 4k_ar_count: got %0d want 2", log_addr.size()); end
        if (log_addr.size() >= 2) begin
            n_checks++; if (log_addr[0] !== 32'h1FC0 || log_len[0] !== 8'd7) begin n_fail++; $display("FAIL 4k_ar0: got %0h/%0d want 1fc0/7", log_addr[0], log_len[0]); end
            n_checks++; if (log_addr[1] !== 32'h2000 || log_len[1] !== 8'd11) begin n_fail++; $display("FAIL 4k_ar1: got %0h/%0d want 2000/11", log_addr[1], log_len[1]); end
        end
        n_checks++; if (push_log.size() != 20 || done_cnt != 1) begin n_fail++; $display("FAIL 4k_beats_done: got %0d/%0d want 20/1", push_log.size(), done_cnt); end
    endtask

    task automatic test_outstanding();
        ar_rand = 0; r_rand = 0; r_on = 0;
        start_req(32'h0, 128);
        repeat (30) @(negedge clk);
        #2;
        n_checks++; if (log_addr.size() != 4) begin n_fail++; $display("FAIL outst_cap_count: got %0d want 4", log_addr.size()); end
        n_checks++; if (bus.arvalid !== 1'b0) begin n_fail++; $display("FAIL outst_cap_arvalid: got %0h want 0", bus.arvalid); end
        r_on = 1;
        wait_done();
        n_checks++; if (log_cyc.size() < 5 || log_cyc[4] <= first_rlast_cyc) begin
            n_fail++; $display("FAIL outst_fifth_ar: got ar_count %0d first_rlast %0d want fifth AR after it", log_cyc.size(), first_rlast_cyc);
        end
        n_checks++; if (max_outs > 4) begin n_fail++; $display("FAIL outst_max: got %0d want <=4", max_outs); end
        n_checks++; if (push_log.size() != 128 || done_cnt != 1) begin n_fail++; $display("FAIL outst_beats_done: got %0d/%0d want 128/1", push_log.size(), done_cnt); end
    endtask

    task automatic test_backpressure();
        ar_rand = 1; r_rand = 0; r_on = 1;
        start_req(32'h3000, 64);
        for (int i = 0; i < 500 && push_log.size() < 8; i++) @(negedge clk);
        @(posedge clk); #1;
        bus.rd_buf_full = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        bus.rd_buf_full = 1'b0;
        wait_done();
        n_checks++; if (full_cycles != 10) begin n_fail++; $display("FAIL bp_window: got %0d want 10", full_cycles); end
        n_checks++; if (rready_while_full != 0) begin n_fail++; $display("FAIL bp_rready: got %0d want 0", rready_while_full); end
        n_checks++; if (push_while_full != 0) begin n_fail++; $display("FAIL bp_push: got %0d want 0", push_while_full); end
        n_checks++; if (push_log.size() != 64) begin n_fail++; $display("FAIL bp_count: got %0d want 64", push_log.size()); end
        for (int i = 0; i < push_log.size() && i < 64; i++) begin
            n_checks++; if (push_log[i] !== 64'(i)) begin n_fail++; $display("FAIL bp_data%0d: got %0h want %0h", i, push_log[i], i); end
        end
    endtask

    task automatic test_small_sizes();
        ar_rand = 0; r_rand = 0; r_on = 1;
        start_req(32'h200, 0);
        n_checks++; if (done_cnt != 1 || done_cyc != acc_cyc) begin n_fail++; $display("FAIL size0_done: got %0d at %0d want 1 at %0d", done_cnt, done_cyc, acc_cyc); end
        wait_done();
        n_checks++; if (log_addr.size() != 0 || arv_acc !== 1'b0) begin n_fail++; $display("FAIL size0_ar: got %0d/%0h want 0/0", log_addr.size(), arv_acc); end
        start_req(32'h40, 1);
        wait_done();
        n_checks++; if (log_addr.size() != 1 || (log_addr.size() == 1 && (log_addr[0] !== 32'h40 || log_len[0] !== 8'd0))) begin
            n_fail++; $display("FAIL size1_ar: got count %0d want one AR 40/0", log_addr.size());
        end
        n_checks++; if (push_log.size() != 1 || done_cnt != 1) begin n_fail++; $display("FAIL size1_beats: got %0d/%0d want 1/1", push_log.size(), done_cnt); end
    endtask

    task automatic test_error();
        ar_rand = 0; r_rand = 1; r_on = 1; err_beat = 3;
        start_req(32'h8000, 8);
        wait_done();
        err_beat = -1;
        n_checks++; if (err_at_done !== 1'b1) begin n_fail++; $display("FAIL err_at_done: got %0h want 1", err_at_done); end
        n_checks++; if (bus.rx_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %0h want 1", bus.rx_err); end
        n_checks++; if (push_log.size() != 8) begin n_fail++; $display("FAIL err_beats: got %0d want 8", push_log.size()); end
        start_req(32'h9000, 4);
        n_checks++; if (err_acc !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %0h want 0", err_acc); end
        wait_done();
        n_checks++; if (err_at_done !== 1'b0 || done_cnt != 1) begin n_fail++; $display("FAIL err_next_req: got %0h/%0d want 0/1", err_at_done, done_cnt); end
    endtask

    task automatic test_reset_mid();
        ar_rand = 0; r_rand = 0; r_on = 1;
        start_req(32'h5000, 128);
        repeat (15) @(negedge clk);
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        slave_clear();
        n_checks++; if ({bus.arvalid, bus.araddr, bus.arlen, bus.rready, bus.rd_buf_push, bus.rx_done, bus.rx_err, bus.rx_req_ready} !== '0) begin
            n_fail++; $display("FAIL mid_reset: got arvalid %0h araddr %0h arlen %0h rready %0h push %0h done %0h err %0h ready %0h want all 0",
                bus.arvalid, bus.araddr, bus.arlen, bus.rready, bus.rd_buf_push, bus.rx_done, bus.rx_err, bus.rx_req_ready);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        start_req(32'h100, 4);
        wait_done();
        n_checks++; if (push_log.size() != 4 || done_cnt != 1) begin n_fail++; $display("FAIL mid_recover: got %0d/%0d want 4/1", push_log.size(), done_cnt); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        int size;
        ar_rand = 1; r_rand = 1; r_on = 1;
        for (int t = 0; t < 16; t++) begin
            a = $urandom & ~32'h7;
            if (t == 0) a = 32'hFFFF_FFC0;
            else if ($urandom_range(0, 1) == 1) a[11:0] = 12'(4096 - 8 * $urandom_range(1, 20));
            size = (t == 0) ? 40 : $urandom_range(1, 150);
            start_req(a, size);
            if (size > 10) begin
                @(posedge clk); #1;
                bus.rx_req = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                bus.rx_req = 1'b0;
            end
            wait_done();
            n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL rnd%0d_done: got %0d want 1", t, done_cnt); end
            n_checks++; if (log_addr.size() != exp_addr.size()) begin n_fail++; $display("FAIL rnd%0d_ar_count: got %0d want %0d", t, log_addr.size(), exp_addr.size()); end
            for (int i = 0; i < log_addr.size() && i < exp_addr.size(); i++) begin
                n_checks++; if (log_addr[i] !== exp_addr[i] || log_len[i] !== exp_len[i]) begin
                    n_fail++; $display("FAIL rnd%0d_ar%0d: got %0h/%0d want %0h/%0d", t, i, log_addr[i], log_len[i], exp_addr[i], exp_len[i]);
                end
            end
            n_checks++; if (push_log.size() != size) begin n_fail++; $display("FAIL rnd%0d_beats: got %0d want %0d", t, push_log.size(), size); end
            for (int i = 0; i < push_log.size() && i < size; i++) begin
                n_checks++; if (push_log[i] !== 64'(i)) begin n_fail++; $display("FAIL rnd%0d_data%0d: got %0h want %0h", t, i, push_log[i], i); end
            end
            n_checks++; if (max_outs > 4) begin n_fail++; $display("FAIL rnd%0d_outst: got %0d want <=4", t, max_outs); end
        end
    endtask

    initial begin
        test_reset();
        test_long();
        test_4k_cross();
        test_outstanding();
        test_backpressure();
        test_small_sizes();
        test_error();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
